reg_file_sb: RTL



---
 rtl/reg_file_sb.sv | 115 +++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - pipelined register file with clear sweep, bypass and busy scoreboard
module reg_file_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int BYPASS        = 1,
  parameter int A0_IDX        = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     WE3,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  output logic [DATA_WIDTH-1:0]    a0,
  input  logic                     issue_en,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  output logic                     issue_ok,
  output logic                     busy1,
  output logic                     busy2
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR  = ADDRESS_WIDTH'(A0_IDX);
  localparam bit BP = (BYPASS != 0);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] clr_idx, clr_idx_nxt;
  logic [DATA_WIDTH-1:0]    regs [DEPTH];
  logic [DEPTH-1:0]         busy;

  logic wr_en;
  logic fwd1, fwd2, fwd_rd;

  assign ready = (state == RUN);
  assign wr_en = ready & WE3 & (AD3 != '0);

  // A same-cycle writeback hits a port only when forwarding is enabled and the target is not x0.
  assign fwd1   = BP & WE3 & (AD3 == AD1) & (AD3 != '0);
  assign fwd2   = BP & WE3 & (AD3 == AD2) & (AD3 != '0);
  assign fwd_rd = BP & WE3 & (AD3 == issue_rd);

  // State register: reset restarts the clear sweep from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Sweep sequencing: leave CLEAR on the edge that zeroes the last register; index never wraps.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    if (state == CLEAR) begin
      if (clr_idx == LAST_IDX) begin
        state_nxt = RUN;
      end else begin
        clr_idx_nxt = clr_idx + 1'b1;
      end
    end
  end

  // Register storage: sweep zeroes one entry per cycle, then writeback owns the write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (wr_en) begin
        regs[AD3] <= WD3;
      end
    end
  end

  // Busy scoreboard: an accepted issue sets its bit and takes priority over a writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (issue_ok && (issue_rd != '0)) begin
      busy[issue_rd] <= 1'b1;
    end else if (wr_en) begin
      busy[AD3] <= 1'b0;
    end
  end

  // Read ports: zero while not ready or for x0, otherwise forwarded or stored data.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    a0  = '0;
    if (ready) begin
      if (AD1 != '0) RD1 = fwd1 ? WD3 : regs[AD1];
      if (AD2 != '0) RD2 = fwd2 ? WD3 : regs[AD2];
      a0 = regs[A0_ADDR];
    end
  end

  // Issue acceptance: a busy destination is only reusable when its producer writes back this cycle.
  assign issue_ok = ready & issue_en &
                    ((issue_rd == '0) | ~busy[issue_rd] | fwd_rd);

  // Operand hazards: a forwarded writeback resolves the hazard in the same cycle.
  assign busy1 = ready & (AD1 != '0) & busy[AD1] & ~fwd1;
  assign busy2 = ready & (AD2 != '0) & busy[AD2] & ~fwd2;

endmodule
